// File: rtl/subdiv_pkg.sv
// Shared constants, payload types and RAM layout helpers for the subdivision blocks.
package subdiv_pkg;

   localparam int unsigned DATA_W         = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 9;
   localparam logic [DATA_W-1:0] Q_ONE    = 32'h0001_0000;

   // Directed edge u -> w, both 1-based vertex indices
   typedef struct packed {
      logic [DATA_W-1:0] u;
      logic [DATA_W-1:0] w;
   } edge_t;

   // First object-RAM word of the face table
   function automatic logic [DATA_W-1:0] face_base(input logic [DATA_W-1:0] vc);
      return (vc * 32'd3) + 32'd1;
   endfunction

   // Neighbor-RAM slot base for 1-based vertex v
   function automatic logic [DATA_W-1:0] slot_base(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] stride);
      return (v - 32'd1) * stride;
   endfunction

endpackage

// File: rtl/nbr_edge_insert.sv
// Looks up w in u's neighbor list and appends it when absent and the list has room.
module nbr_edge_insert
   import subdiv_pkg::*;
#(
   parameter int unsigned MAX_NEIGHBOR_COUNT = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  edge_t             nbr_edge,
   output logic              ack_c,
   output logic              ovf_c,
   output logic [DATA_W-1:0] nbr_a_c,
   output logic              nbr_we_c,
   output logic [DATA_W-1:0] nbr_di_c,
   input  logic [DATA_W-1:0] nbr_do
);

   typedef enum logic [2:0] {S_IDLE, EDGE_CNT, EDGE_SCAN, EDGE_APPEND, EDGE_CNT_WR} ins_state_t;

   localparam logic [DATA_W-1:0] STRIDE   = DATA_W'(MAX_NEIGHBOR_COUNT);
   localparam logic [DATA_W-1:0] CNT_FULL = DATA_W'(MAX_NEIGHBOR_COUNT - 1);

   ins_state_t        state_q, state_d;
   logic [DATA_W-1:0] w_q, w_d, base_q, base_d, cnt_q, cnt_d, idx_q, idx_d;
   logic [1:0]        ph_q, ph_d;
   logic [DATA_W-1:0] cnt_now;
   logic              miss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         w_q     <= '0;
         base_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         ph_q    <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ph_q    <= ph_d;
      end
   end

   // Reads issued here return on nbr_do two cycles later (address register + RAM)
   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      base_d   = base_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      ph_d     = ph_q;
      ack_c    = 1'b0;
      ovf_c    = 1'b0;
      nbr_a_c  = '0;
      nbr_we_c = 1'b0;
      nbr_di_c = '0;
      cnt_now  = cnt_q;
      miss     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               w_d     = nbr_edge.w;
               base_d  = slot_base(nbr_edge.u, STRIDE);
               nbr_a_c = slot_base(nbr_edge.u, STRIDE);
               ph_d    = 2'd0;
               state_d = EDGE_CNT;
            end
         end
         EDGE_CNT: begin
            if (ph_q == 2'd0) begin
               ph_d = 2'd1;
            end else begin
               cnt_now = nbr_do;
               cnt_d   = nbr_do;
               idx_d   = '0;
               ph_d    = 2'd0;
               if (nbr_do == '0) miss = 1'b1;
               else              state_d = EDGE_SCAN;
            end
         end
         EDGE_SCAN: begin
            case (ph_q)
               2'd0: begin
                  nbr_a_c = base_q + 32'd1 + idx_q;
                  ph_d    = 2'd1;
               end
               2'd1: ph_d = 2'd2;
               default: begin
                  ph_d = 2'd0;
                  if (nbr_do == w_q) begin
                     ack_c   = 1'b1;
                     state_d = S_IDLE;
                  end else if (idx_q + 32'd1 == cnt_q) begin
                     miss = 1'b1;
                  end else begin
                     idx_d = idx_q + 32'd1;
                  end
               end
            endcase
         end
         EDGE_APPEND: begin
            nbr_a_c  = base_q + cnt_q + 32'd1;
            nbr_we_c = 1'b1;
            nbr_di_c = w_q;
            state_d  = EDGE_CNT_WR;
         end
         EDGE_CNT_WR: begin
            nbr_a_c  = base_q;
            nbr_we_c = 1'b1;
            nbr_di_c = cnt_q + 32'd1;
            ack_c    = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Not found: append unless the list is already full
      if (miss) begin
         if (cnt_now == CNT_FULL) begin
            ack_c   = 1'b1;
            ovf_c   = 1'b1;
            state_d = S_IDLE;
         end else begin
            state_d = EDGE_APPEND;
         end
      end
   end

endmodule

// File: rtl/neighbor_builder.sv
// Builds per-vertex neighbor lists in neighbor RAM from the face table in object RAM.
module neighbor_builder
   import subdiv_pkg::*;
#(
   parameter int unsigned MAX_NEIGHBOR_COUNT = 10,
   parameter int unsigned ADDR_WIDTH         = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     vertex_count,
   input  logic [DATA_W-1:0]     face_count,
   output logic                  RAM_OBJ_EN,
   output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
   output logic [3:0]            RAM_OBJ_WE,
   output logic [DATA_W-1:0]     RAM_OBJ_Di,
   input  logic [DATA_W-1:0]     RAM_OBJ_Do,
   output logic                  RAM_NBR_EN,
   output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
   output logic [3:0]            RAM_NBR_WE,
   output logic [DATA_W-1:0]     RAM_NBR_Di,
   input  logic [DATA_W-1:0]     RAM_NBR_Do,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf_err,
   output logic                  idx_err
);

   typedef enum logic [2:0] {IDLE, CHECK, CLEAR, FACE_RD, EDGE_RUN, FINISH} state_t;

   localparam logic [DATA_W-1:0] STRIDE = DATA_W'(MAX_NEIGHBOR_COUNT);
   localparam logic [63:0]       LIMIT  = 64'd1 << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     vc_q, vc_d, fc_q, fc_d, face_q, face_d, faddr_q, faddr_d, v_q, v_d;
   logic [DATA_W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
   logic [2:0]            ph_q, ph_d, e_q, e_d;
   logic                  obj_en_d, nbr_en_d, busy_d, done_d, ovf_d, idx_d;
   logic [ADDR_WIDTH-1:0] obj_a_d, nbr_a_d;
   logic [3:0]            nbr_we_d;
   logic [DATA_W-1:0]     nbr_di_d;

   logic                  req_c, ins_ack_c, ins_ovf_c, ins_we_c, edge_ok, advance;
   edge_t                 edge_c;
   logic [DATA_W-1:0]     ins_a_c, ins_di_c;

   nbr_edge_insert #(.MAX_NEIGHBOR_COUNT(MAX_NEIGHBOR_COUNT)) u_ins (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_c),
      .nbr_edge (edge_c),
      .ack_c    (ins_ack_c),
      .ovf_c    (ins_ovf_c),
      .nbr_a_c  (ins_a_c),
      .nbr_we_c (ins_we_c),
      .nbr_di_c (ins_di_c),
      .nbr_do   (RAM_NBR_Do)
   );

   assign RAM_OBJ_WE = '0;
   assign RAM_OBJ_Di = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vc_q <= '0; fc_q <= '0; face_q <= '0; faddr_q <= '0; v_q <= '0;
         a_q <= '0; b_q <= '0; c_q <= '0; ph_q <= '0; e_q <= '0;
         RAM_OBJ_EN <= 1'b0; RAM_OBJ_A <= '0;
         RAM_NBR_EN <= 1'b0; RAM_NBR_A <= '0; RAM_NBR_WE <= '0; RAM_NBR_Di <= '0;
         busy <= 1'b0; done <= 1'b0; ovf_err <= 1'b0; idx_err <= 1'b0;
      end else begin
         state_q <= state_d;
         vc_q <= vc_d; fc_q <= fc_d; face_q <= face_d; faddr_q <= faddr_d; v_q <= v_d;
         a_q <= a_d; b_q <= b_d; c_q <= c_d; ph_q <= ph_d; e_q <= e_d;
         RAM_OBJ_EN <= obj_en_d; RAM_OBJ_A <= obj_a_d;
         RAM_NBR_EN <= nbr_en_d; RAM_NBR_A <= nbr_a_d; RAM_NBR_WE <= nbr_we_d; RAM_NBR_Di <= nbr_di_d;
         busy <= busy_d; done <= done_d; ovf_err <= ovf_d; idx_err <= idx_d;
      end
   end

   // Ordered edge selection for the current face
   always_comb begin
      case (e_q)
         3'd0:    begin edge_c.u = a_q; edge_c.w = b_q; end
         3'd1:    begin edge_c.u = a_q; edge_c.w = c_q; end
         3'd2:    begin edge_c.u = b_q; edge_c.w = a_q; end
         3'd3:    begin edge_c.u = b_q; edge_c.w = c_q; end
         3'd4:    begin edge_c.u = c_q; edge_c.w = a_q; end
         default: begin edge_c.u = c_q; edge_c.w = b_q; end
      endcase
      edge_ok = (edge_c.u != '0) && (edge_c.w != '0) && (edge_c.u <= vc_q) &&
                (edge_c.w <= vc_q) && (edge_c.u != edge_c.w);
   end

   always_comb begin
      state_d = state_q;
      vc_d = vc_q; fc_d = fc_q; face_d = face_q; faddr_d = faddr_q; v_d = v_q;
      a_d = a_q; b_d = b_q; c_d = c_q; ph_d = ph_q; e_d = e_q;
      ovf_d = ovf_err; idx_d = idx_err;
      obj_a_d = '0; nbr_a_d = '0; nbr_we_d = '0; nbr_di_d = '0;
      req_c = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               vc_d    = vertex_count;
               fc_d    = face_count;
               ovf_d   = 1'b0;
               idx_d   = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (({32'd0, vc_q} * 64'(MAX_NEIGHBOR_COUNT) > LIMIT) ||
                ({32'd0, vc_q} * 64'd3 + 64'd1 + {32'd0, fc_q} * 64'd3 > LIMIT)) begin
               idx_d   = 1'b1;
               state_d = FINISH;
            end else if (vc_q == '0) begin
               state_d = FINISH;
            end else begin
               v_d     = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            nbr_a_d  = ADDR_WIDTH'(slot_base(v_q + 32'd1, STRIDE));
            nbr_we_d = 4'hF;
            v_d      = v_q + 32'd1;
            if (v_q + 32'd1 == vc_q) begin
               if (fc_q == '0) begin
                  state_d = FINISH;
               end else begin
                  face_d  = '0;
                  faddr_d = face_base(vc_q);
                  ph_d    = '0;
                  state_d = FACE_RD;
               end
            end
         end
         FACE_RD: begin
            // Issue three reads, capture each two cycles later
            if (ph_q < 3'd3) obj_a_d = ADDR_WIDTH'(faddr_q + 32'(ph_q));
            ph_d = ph_q + 3'd1;
            case (ph_q)
               3'd2: a_d = RAM_OBJ_Do;
               3'd3: b_d = RAM_OBJ_Do;
               3'd4: begin
                  c_d     = RAM_OBJ_Do;
                  e_d     = '0;
                  state_d = EDGE_RUN;
               end
               default: ;
            endcase
         end
         EDGE_RUN: begin
            if (!edge_ok) begin
               idx_d   = 1'b1;
               advance = 1'b1;
            end else begin
               req_c    = 1'b1;
               nbr_a_d  = ADDR_WIDTH'(ins_a_c);
               nbr_we_d = {4{ins_we_c}};
               nbr_di_d = ins_di_c;
               if (ins_ack_c) begin
                  advance = 1'b1;
                  if (ins_ovf_c) ovf_d = 1'b1;
               end
            end
            if (advance) begin
               if (e_q == 3'd5) begin
                  if (face_q + 32'd1 == fc_q) begin
                     state_d = FINISH;
                  end else begin
                     face_d  = face_q + 32'd1;
                     faddr_d = faddr_q + 32'd3;
                     ph_d    = '0;
                     state_d = FACE_RD;
                  end
               end else begin
                  e_d = e_q + 3'd1;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d   = (state_d != IDLE) && (state_d != FINISH);
      done_d   = (state_d == FINISH);
      obj_en_d = busy_d;
      // The final count write lands in the FINISH cycle, so keep EN up for it
      nbr_en_d = busy_d || (nbr_we_d != '0);
   end

endmodule

// File: tb/tb_neighbor_builder.sv
// Directed table-driven bench for neighbor_builder with behavioural synchronous RAMs.
module tb_neighbor_builder;

   localparam int unsigned AW    = 9;
   localparam int unsigned DEPTH = 512;

   typedef struct packed {
      logic                  sel;
      logic [31:0]           vc;
      logic [31:0]           fc;
      logic [1:0][2:0][7:0]  faces;
      logic [2:0]            nchk;
      logic                  ovf;
      logic                  idx;
      logic [3:0][3:0][7:0]  exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start0, start1, prefill0, prefill1;
   logic [31:0] vertex_count, face_count;

   logic          obj_en0, obj_en1, nbr_en0, nbr_en1;
   logic [AW-1:0] obj_a0, obj_a1, nbr_a0, nbr_a1;
   logic [3:0]    obj_we0, obj_we1, nbr_we0, nbr_we1;
   logic [31:0]   obj_di0, obj_di1, nbr_di0, nbr_di1;
   logic [31:0]   obj_do0, obj_do1, nbr_do0, nbr_do1;
   logic          busy0, busy1, done0, done1, ovf0, ovf1, idx0, idx1;

   logic [31:0] obj_mem  [DEPTH];
   logic [31:0] nbr_mem0 [DEPTH];
   logic [31:0] nbr_mem1 [DEPTH];

   vec_t vecs [10];
   int   passed = 0;
   int   total  = 0;

   neighbor_builder #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(AW)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .vertex_count(vertex_count), .face_count(face_count),
      .RAM_OBJ_EN(obj_en0), .RAM_OBJ_A(obj_a0), .RAM_OBJ_WE(obj_we0), .RAM_OBJ_Di(obj_di0), .RAM_OBJ_Do(obj_do0),
      .RAM_NBR_EN(nbr_en0), .RAM_NBR_A(nbr_a0), .RAM_NBR_WE(nbr_we0), .RAM_NBR_Di(nbr_di0), .RAM_NBR_Do(nbr_do0),
      .busy(busy0), .done(done0), .ovf_err(ovf0), .idx_err(idx0));

   neighbor_builder #(.MAX_NEIGHBOR_COUNT(3), .ADDR_WIDTH(AW)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .vertex_count(vertex_count), .face_count(face_count),
      .RAM_OBJ_EN(obj_en1), .RAM_OBJ_A(obj_a1), .RAM_OBJ_WE(obj_we1), .RAM_OBJ_Di(obj_di1), .RAM_OBJ_Do(obj_do1),
      .RAM_NBR_EN(nbr_en1), .RAM_NBR_A(nbr_a1), .RAM_NBR_WE(nbr_we1), .RAM_NBR_Di(nbr_di1), .RAM_NBR_Do(nbr_do1),
      .busy(busy1), .done(done1), .ovf_err(ovf1), .idx_err(idx1));

   always @(posedge clk) begin
      if (obj_en0) obj_do0 <= obj_mem[obj_a0];
      if (obj_en1) obj_do1 <= obj_mem[obj_a1];
   end

   always @(posedge clk) begin
      if (prefill0) begin
         for (int i = 0; i < DEPTH; i++) nbr_mem0[i] <= 32'hDEAD_0000 | 32'(i);
      end else if (nbr_en0) begin
         if (nbr_we0 == 4'hF) nbr_mem0[nbr_a0] <= nbr_di0;
         nbr_do0 <= nbr_mem0[nbr_a0];
      end
   end

   always @(posedge clk) begin
      if (prefill1) begin
         for (int i = 0; i < DEPTH; i++) nbr_mem1[i] <= 32'hBEEF_0000 | 32'(i);
      end else if (nbr_en1) begin
         if (nbr_we1 == 4'hF) nbr_mem1[nbr_a1] <= nbr_di1;
         nbr_do1 <= nbr_mem1[nbr_a1];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [23:0] fa(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [31:0] sl(input int cnt, input int n1, input int n2, input int n3);
      return {8'(n3), 8'(n2), 8'(n1), 8'(cnt)};
   endfunction

   task automatic set_vec(input int i, input logic sel, input int vc, input int fc,
                          input logic [23:0] f0, input logic [23:0] f1, input int nchk,
                          input logic ovf, input logic idx,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] s3, input logic [31:0] s4);
      vecs[i].sel   = sel;
      vecs[i].vc    = 32'(vc);
      vecs[i].fc    = 32'(fc);
      vecs[i].faces = {f1, f0};
      vecs[i].nchk  = 3'(nchk);
      vecs[i].ovf   = ovf;
      vecs[i].idx   = idx;
      vecs[i].exp   = {s4, s3, s2, s1};
   endtask

   task automatic pulse_start(input logic sel);
      @(negedge clk);
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input logic sel, output int dones);
      logic seen;
      seen  = 1'b0;
      dones = 0;
      for (int i = 0; i < 6000 && !seen; i++) begin
         @(negedge clk);
         if (sel ? done1 : done0) begin seen = 1'b1; dones++; end
      end
      check("done_seen", 32'(seen), 32'd1);
      repeat (4) begin
         @(negedge clk);
         if (sel ? done1 : done0) dones++;
      end
   endtask

   task automatic load_vec(input int i);
      int fb;
      fb = 3 * int'(vecs[i].vc) + 1;
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < 3; k++)
            if (f < int'(vecs[i].fc) && fb + 3 * f + k < DEPTH)
               obj_mem[fb + 3 * f + k] = 32'(vecs[i].faces[f][k]);
      vertex_count = vecs[i].vc;
      face_count   = vecs[i].fc;
      @(negedge clk);
      if (vecs[i].sel) prefill1 = 1'b1; else prefill0 = 1'b1;
      @(negedge clk);
      prefill0 = 1'b0;
      prefill1 = 1'b0;
   endtask

   task automatic check_slots(input int i);
      int mnc, base, cnt;
      logic [31:0] word;
      mnc = vecs[i].sel ? 3 : 10;
      for (int s = 0; s < int'(vecs[i].nchk); s++) begin
         base = s * mnc;
         word = vecs[i].sel ? nbr_mem1[base] : nbr_mem0[base];
         cnt  = int'(vecs[i].exp[s][0]);
         check($sformatf("v%0d_slot%0d_count", i, s + 1), word, 32'(cnt));
         for (int k = 1; k <= cnt; k++) begin
            word = vecs[i].sel ? nbr_mem1[base + k] : nbr_mem0[base + k];
            check($sformatf("v%0d_slot%0d_nbr%0d", i, s + 1, k), word, 32'(vecs[i].exp[s][k]));
         end
      end
   endtask

   task automatic apply_vec(input int i);
      int   d;
      logic sel;
      sel = vecs[i].sel;
      load_vec(i);
      pulse_start(sel);
      wait_done(sel, d);
      check($sformatf("v%0d_done_pulses", i), 32'(d), 32'd1);
      check($sformatf("v%0d_busy_after", i), 32'(sel ? busy1 : busy0), 32'd0);
      check($sformatf("v%0d_ovf_err", i), 32'(sel ? ovf1 : ovf0), 32'(vecs[i].ovf));
      check($sformatf("v%0d_idx_err", i), 32'(sel ? idx1 : idx0), 32'(vecs[i].idx));
      check_slots(i);
   endtask

   task automatic check_quiet(input string name);
      check({name, "_flags0"}, 32'({busy0, done0, ovf0, idx0, obj_en0, nbr_en0, nbr_we0, obj_we0}), 32'd0);
      check({name, "_bus0"}, 32'(nbr_a0) | 32'(obj_a0) | nbr_di0 | obj_di0, 32'd0);
      check({name, "_flags1"}, 32'({busy1, done1, ovf1, idx1, obj_en1, nbr_en1, nbr_we1, obj_we1}), 32'd0);
      check({name, "_bus1"}, 32'(nbr_a1) | 32'(obj_a1) | nbr_di1 | obj_di1, 32'd0);
   endtask

   initial begin
      int   d, wr;
      logic hit;
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; prefill0 = 1'b0; prefill1 = 1'b0;
      vertex_count = '0; face_count = '0;
      for (int i = 0; i < DEPTH; i++) obj_mem[i] = '0;

      set_vec(0, 1'b0, 3, 1, fa(1,2,3), fa(0,0,0), 3, 1'b0, 1'b0,
              sl(2,2,3,0), sl(2,1,3,0), sl(2,1,2,0), sl(0,0,0,0));
      set_vec(1, 1'b0, 4, 2, fa(1,2,3), fa(1,3,4), 4, 1'b0, 1'b0,
              sl(3,2,3,4), sl(2,1,3,0), sl(3,1,2,4), sl(2,1,3,0));
      set_vec(2, 1'b1, 4, 2, fa(1,2,3), fa(1,3,4), 4, 1'b1, 1'b0,
              sl(2,2,3,0), sl(2,1,3,0), sl(2,1,2,0), sl(2,1,3,0));
      set_vec(3, 1'b0, 3, 1, fa(1,0,2), fa(0,0,0), 3, 1'b0, 1'b1,
              sl(1,2,0,0), sl(1,1,0,0), sl(0,0,0,0), sl(0,0,0,0));
      set_vec(4, 1'b0, 3, 1, fa(1,2,4), fa(0,0,0), 3, 1'b0, 1'b1,
              sl(1,2,0,0), sl(1,1,0,0), sl(0,0,0,0), sl(0,0,0,0));
      set_vec(5, 1'b0, 100, 1, fa(1,2,3), fa(0,0,0), 0, 1'b0, 1'b1,
              sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0));
      set_vec(6, 1'b0, 3, 200, fa(1,2,3), fa(0,0,0), 0, 1'b0, 1'b1,
              sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0));
      set_vec(7, 1'b0, 2, 0, fa(0,0,0), fa(0,0,0), 2, 1'b0, 1'b0,
              sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0));
      set_vec(8, 1'b0, 0, 0, fa(0,0,0), fa(0,0,0), 0, 1'b0, 1'b0,
              sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0), sl(0,0,0,0));
      set_vec(9, 1'b0, 3, 1, fa(2,2,1), fa(0,0,0), 3, 1'b0, 1'b1,
              sl(1,2,0,0), sl(1,1,0,0), sl(0,0,0,0), sl(0,0,0,0));

      repeat (3) @(negedge clk);
      check_quiet("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_quiet("after_reset");

      for (int i = 0; i < 10; i++) apply_vec(i);

      // Asynchronous reset while the inserter is scanning a list
      load_vec(1);
      pulse_start(1'b0);
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(posedge clk);
         #1;
         if (dut0.u_ins.state_q == 3'd2) hit = 1'b1;
      end
      check("scan_reached", 32'(hit), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_quiet("mid_scan_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr = 0;
      repeat (20) begin
         @(negedge clk);
         if (nbr_en0 && nbr_we0 != 4'h0) wr++;
      end
      check("writes_after_reset", 32'(wr), 32'd0);
      check("busy_after_reset", 32'(busy0), 32'd0);
      apply_vec(0);

      // Second start while busy must be ignored
      load_vec(0);
      pulse_start(1'b0);
      repeat (8) @(negedge clk);
      check("busy_before_restart", 32'(busy0), 32'd1);
      vertex_count = 32'd2;
      face_count   = 32'd0;
      pulse_start(1'b0);
      wait_done(1'b0, d);
      check("restart_done_pulses", 32'(d), 32'd1);
      check("restart_idx_err", 32'(idx0), 32'd0);
      check_slots(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
